// File: rtl/prbs_chk.sv
// Receive-side PRBS31 checker (inverted x^31 + x^28 + 1) with lock tracking and saturating error counters.
// Optional PRBS_CHK_ERR_INJECT_EN adds inj_i, which flips bit 0 of an accepted beat before checking.
module prbs_chk #(
  parameter int NBITS       = 32,
  parameter int FRAME_LEN   = 256,
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_CNT  = 4,
  parameter int INV_PATTERN = 1
) (
  input  logic             rx_user_clk_i,
  input  logic             rx_user_rst_i,
  input  logic [NBITS-1:0] rx_data_i,
  input  logic [1:0]       rx_vldb_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  input  logic             rx_last_i,
  input  logic             rx_user_i,
`ifdef PRBS_CHK_ERR_INJECT_EN
  input  logic             inj_i,
`endif
  input  logic             clear_i,
  output logic             lock_o,
  output logic             beat_err_o,
  output logic [31:0]      bit_err_cnt_o,
  output logic [15:0]      last_err_cnt_o,
  output logic [15:0]      vldb_err_cnt_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a beat transfers on a rising edge where rx_valid_i and rx_ready_o
  // are both high; ready is low only while reset is asserted, so there is no back-pressure.

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_SYNC     = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam int FCW = $clog2(FRAME_LEN);
  localparam int GCW = $clog2(LOCK_CNT + 1);
  localparam int BCW = $clog2(UNLOCK_CNT + 1);
  localparam int PCW = $clog2(NBITS + 1);
  localparam int TAP = 3;  // distance between the x^31 and x^28 taps
  localparam int EW  = NBITS - 1 + TAP + 1;

  localparam logic [FCW-1:0] FRAME_END = FCW'(FRAME_LEN - 1);
  localparam logic [GCW-1:0] GOOD_LAST = GCW'(LOCK_CNT - 1);
  localparam logic [BCW-1:0] BAD_LAST  = BCW'(UNLOCK_CNT - 1);
  localparam logic           INV_BIT   = (INV_PATTERN != 0);

  logic [1:0]       state_q, state_d;
  logic [GCW-1:0]   good_q, good_d;
  logic [BCW-1:0]   bad_q, bad_d;
  logic [NBITS-2:0] hist_q, hist_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [NBITS-1:0] mism_q, mism_d;
  logic             cnt_en_q, cnt_en_d;
  logic             beat_err_q;
  logic             lock_q;
  logic [PCW-1:0]   pop_q;
  logic [31:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]      last_cnt_q, last_cnt_d;
  logic [15:0]      vldb_cnt_q, vldb_cnt_d;

  logic             acc_c;
  logic             vldb_ok_c;
  logic             do_chk_c;
  logic             beat_bad_c;
  logic             last_inc_c;
  logic [NBITS-1:0] data_c;
  logic [NBITS-1:0] pred_c;
  logic [NBITS-1:0] mism_c;
  logic [EW-1:0]    ext_c;
  logic [32:0]      bit_sum_c;
  logic             unused_sideband;

  assign unused_sideband = rx_user_i;

  assign rx_ready_o = ~rx_user_rst_i;
  assign acc_c      = rx_valid_i & rx_ready_o;
  assign vldb_ok_c  = (rx_vldb_i == 2'b11);

`ifdef PRBS_CHK_ERR_INJECT_EN
  assign data_c = {rx_data_i[NBITS-1:1], rx_data_i[0] ^ inj_i};
`else
  assign data_c = rx_data_i;
`endif

  // Serial stream view: history holds bits n-31..n-1, so bit i of the word sits at ext[i+31].
  assign ext_c = {data_c[TAP:0], hist_q};

  always_comb begin
    pred_c = '0;
    for (int i = 0; i < NBITS; i++) begin
      pred_c[i] = ext_c[i] ^ ext_c[i+TAP] ^ INV_BIT;
    end
  end

  assign mism_c     = data_c ^ pred_c;
  assign beat_bad_c = |mism_c;
  // History is valid exactly when the FSM has left UNLOCKED.
  assign do_chk_c   = acc_c & vldb_ok_c & (state_q != ST_UNLOCKED);
  assign mism_d     = do_chk_c ? mism_c : '0;
  assign cnt_en_d   = do_chk_c & (state_q == ST_LOCKED);

  function automatic logic [PCW-1:0] popcnt(input logic [NBITS-1:0] v);
    logic [PCW-1:0] s;
    s = '0;
    for (int i = 0; i < NBITS; i++) begin
      s = s + PCW'(v[i]);
    end
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    hist_d  = hist_q;
    if (acc_c) begin
      if (!vldb_ok_c) begin
        state_d = ST_UNLOCKED;
        good_d  = '0;
        bad_d   = '0;
      end else begin
        hist_d = data_c[NBITS-1:1];
        case (state_q)
          ST_UNLOCKED: begin
            state_d = ST_SYNC;
            good_d  = '0;
            bad_d   = '0;
          end
          ST_SYNC: begin
            if (beat_bad_c) begin
              good_d = '0;
            end else if (good_q == GOOD_LAST) begin
              state_d = ST_LOCKED;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!beat_bad_c) begin
              bad_d = '0;
            end else if (bad_q == BAD_LAST) begin
              state_d = ST_UNLOCKED;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end
          default: state_d = ST_UNLOCKED;
        endcase
      end
    end
  end

  // Frame position; an early last restarts the frame so the next beat is position 0.
  always_comb begin
    fcnt_d     = fcnt_q;
    last_inc_c = 1'b0;
    if (acc_c) begin
      if (fcnt_q == FRAME_END) begin
        fcnt_d     = '0;
        last_inc_c = ~rx_last_i;
      end else if (rx_last_i) begin
        fcnt_d     = '0;
        last_inc_c = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign bit_sum_c = {1'b0, bit_cnt_q} + 33'(pop_q);

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    last_cnt_d = last_cnt_q;
    vldb_cnt_d = vldb_cnt_q;
    if (clear_i) begin
      bit_cnt_d  = '0;
      last_cnt_d = '0;
      vldb_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_sum_c[32] ? '1 : bit_sum_c[31:0];
      if (last_inc_c && (last_cnt_q != '1)) begin
        last_cnt_d = last_cnt_q + 1'b1;
      end
      if (acc_c && !vldb_ok_c && (vldb_cnt_q != '1)) begin
        vldb_cnt_d = vldb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge rx_user_clk_i) begin
    if (rx_user_rst_i) begin
      state_q    <= ST_UNLOCKED;
      good_q     <= '0;
      bad_q      <= '0;
      hist_q     <= '0;
      fcnt_q     <= '0;
      mism_q     <= '0;
      cnt_en_q   <= 1'b0;
      beat_err_q <= 1'b0;
      lock_q     <= 1'b0;
      pop_q      <= '0;
      bit_cnt_q  <= '0;
      last_cnt_q <= '0;
      vldb_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      hist_q     <= hist_d;
      fcnt_q     <= fcnt_d;
      mism_q     <= mism_d;
      cnt_en_q   <= cnt_en_d;
      beat_err_q <= |mism_q;
      lock_q     <= (state_q == ST_LOCKED);
      pop_q      <= cnt_en_q ? popcnt(mism_q) : '0;
      bit_cnt_q  <= bit_cnt_d;
      last_cnt_q <= last_cnt_d;
      vldb_cnt_q <= vldb_cnt_d;
    end
  end

  assign lock_o         = lock_q;
  assign beat_err_o     = beat_err_q;
  assign bit_err_cnt_o  = bit_cnt_q;
  assign last_err_cnt_o = last_cnt_q;
  assign vldb_err_cnt_o = vldb_cnt_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_prbs_chk.sv
// Self-checking bench for prbs_chk: serial PRBS31 source, a bit-serial reference checker and
// delay-line scoreboards for lock/beat_err and the bit error counter.
module tb_prbs_chk;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_data;
  logic [1:0]  rx_vldb;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_last;
  logic        rx_user;
  logic        clr;
  logic        lock;
  logic        beat_err;
  logic [31:0] bit_cnt;
  logic [15:0] last_cnt;
  logic [15:0] vldb_cnt;
  logic [1:0]  dbg_state;
`ifdef PRBS_CHK_ERR_INJECT_EN
  logic        inj;
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  prbs_chk dut (
    .rx_user_clk_i (clk),
    .rx_user_rst_i (rst),
    .rx_data_i     (rx_data),
    .rx_vldb_i     (rx_vldb),
    .rx_valid_i    (rx_valid),
    .rx_ready_o    (rx_ready),
    .rx_last_i     (rx_last),
    .rx_user_i     (rx_user),
`ifdef PRBS_CHK_ERR_INJECT_EN
    .inj_i         (inj),
`endif
    .clear_i       (clr),
    .lock_o        (lock),
    .beat_err_o    (beat_err),
    .bit_err_cnt_o (bit_cnt),
    .last_err_cnt_o(last_cnt),
    .vldb_err_cnt_o(vldb_cnt),
    .dbg_state_o   (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // PRBS31 source, one serial bit at a time, output inverted
  logic [30:0] gen_sh = 31'h1234_5679;

  task automatic gen_word(output logic [31:0] w);
    logic nb;
    for (int i = 0; i < 32; i++) begin
      nb     = gen_sh[0] ^ gen_sh[3];
      gen_sh = {nb, gen_sh[30:1]};
      w[i]   = ~nb;
    end
  endtask

  // Reference checker state
  int          m_state;
  int          m_good;
  int          m_bad;
  int          m_fcnt;
  int          m_last;
  int          m_vldb;
  longint      m_bit;
  logic [30:0] m_rh;
  int          tb_pos;

  logic [1:0]  exp_q[$];  // {lock, beat_err}, visible one edge after the beat
  logic [5:0]  pop_q[$];  // counted popcounts, added two edges after the beat

  task automatic model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_fcnt = 0;
    m_last = 0; m_vldb = 0; m_bit = 0; m_rh = '0;
    tb_pos = 0;
    exp_q.delete();
    pop_q.delete();
  endtask

  task automatic cycle(input logic valid, input logic [31:0] data, input logic [1:0] vldb,
                       input logic last, input logic clr_in, input logic inj_in);
    logic [31:0] d;
    logic [1:0]  e;
    logic        p;
    logic        lerr;
    int          nerr;
    int          pend;
    bit          chk;
    bit          cnt;
    rx_valid = valid;
    rx_data  = data;
    rx_vldb  = vldb;
    rx_last  = last;
    clr      = clr_in;
    rx_user  = 1'($urandom_range(0, 1));
`ifdef PRBS_CHK_ERR_INJECT_EN
    inj = inj_in;
`endif
    @(posedge clk);
    #1;
    d    = data;
    d[0] = d[0] ^ (INJ_EN & inj_in);
    nerr = 0;
    chk  = 0;
    cnt  = 0;
    pend = (pop_q.size() == 2) ? int'(pop_q.pop_front()) : 0;
    if (clr_in) m_bit = 0;
    else begin
      m_bit = m_bit + pend;
      if (m_bit > 64'hFFFF_FFFF) m_bit = 64'hFFFF_FFFF;
    end
    if (valid) begin
      if (m_fcnt == 255) begin lerr = !last; m_fcnt = 0; end
      else if (last) begin lerr = 1'b1; m_fcnt = 0; end
      else begin lerr = 1'b0; m_fcnt++; end
      if (!clr_in && lerr && m_last < 65535) m_last++;
      if (vldb != 2'b11) begin
        if (!clr_in && m_vldb < 65535) m_vldb++;
        m_state = 0; m_good = 0; m_bad = 0;
      end else begin
        for (int i = 0; i < 32; i++) begin
          p = ~(m_rh[0] ^ m_rh[3]);
          if (m_state != 0 && d[i] != p) nerr++;
          m_rh = {d[i], m_rh[30:1]};
        end
        if (m_state == 0) begin
          m_state = 1; m_good = 0;
        end else begin
          chk = 1;
          cnt = (m_state == 2);
          if (m_state == 1) begin
            if (nerr == 0) begin
              m_good++;
              if (m_good == 16) begin m_state = 2; m_good = 0; m_bad = 0; end
            end else m_good = 0;
          end else begin
            if (nerr != 0) begin
              m_bad++;
              if (m_bad == 4) begin m_state = 0; m_bad = 0; end
            end else m_bad = 0;
          end
        end
      end
    end
    if (clr_in) begin m_last = 0; m_vldb = 0; end
    exp_q.push_back({m_state == 2, chk && nerr != 0});
    pop_q.push_back(cnt ? 6'(nerr) : 6'd0);
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      check_eq("lock_o", 32'(lock), 32'(e[1]));
      check_eq("beat_err_o", 32'(beat_err), 32'(e[0]));
    end
    check_eq("bit_err_cnt", bit_cnt, m_bit[31:0]);
    check_eq("last_err_cnt", 32'(last_cnt), 32'(m_last));
    check_eq("vldb_err_cnt", 32'(vldb_cnt), 32'(m_vldb));
  endtask

  // One beat on the frame schedule; force_last marks an early frame end and restarts the schedule.
  task automatic put_beat(input logic [31:0] w, input logic [1:0] vldb, input logic force_last,
                          input logic clr_in, input logic inj_in);
    logic last;
    last = force_last | (tb_pos == 255);
    if (force_last && tb_pos != 255) tb_pos = 0;
    else tb_pos = (tb_pos + 1) % 256;
    cycle(1'b1, w, vldb, last, clr_in, inj_in);
  endtask

  task automatic send_clean(input int n);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      gen_word(w);
      put_beat(w, 2'b11, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    clr      = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(rx_ready), 32'd0);
    check_eq("rst_lock", 32'(lock), 32'd0);
    check_eq("rst_beat_err", 32'(beat_err), 32'd0);
    check_eq("rst_bit_cnt", bit_cnt, 32'd0);
    check_eq("rst_last_cnt", 32'(last_cnt), 32'd0);
    check_eq("rst_vldb_cnt", 32'(vldb_cnt), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("ready_after_rst", 32'(rx_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    int lock_at;
    rx_data = '0;
    rx_vldb = 2'b11;
    rx_user = 1'b0;
`ifdef PRBS_CHK_ERR_INJECT_EN
    inj = 1'b0;
`endif
    do_reset();

    // Clean lock and long clean run
    lock_at = 0;
    for (int k = 1; k <= 10000; k++) begin
      send_clean(1);
      if (lock_at == 0 && lock) lock_at = k;
    end
    check_eq("lock_latency", 32'(lock_at), 32'd18);
    check_eq("clean_bit_cnt", bit_cnt, 32'd0);
    check_eq("clean_last_cnt", 32'(last_cnt), 32'd0);

    // Single flipped bit while locked
    gen_word(w);
    w[5] = ~w[5];
    put_beat(w, 2'b11, 1'b0, 1'b0, 1'b0);
    send_clean(1);
    check_eq("single_err_pulse", 32'(beat_err), 32'd1);
    send_clean(3);
    check_eq("single_err_bits", bit_cnt, 32'd3);
    check_eq("single_err_lock", 32'(lock), 32'd1);

    // Loss of lock on four zero beats, then relock
    for (int k = 0; k < 4; k++) put_beat(32'h0, 2'b11, 1'b0, 1'b0, 1'b0);
    send_clean(1);
    check_eq("unlock", 32'(lock), 32'd0);
    send_clean(16);
    check_eq("relock_early", 32'(lock), 32'd0);
    send_clean(1);
    check_eq("relock", 32'(lock), 32'd1);

    // Early frame end, then a correctly spaced last
    while (tb_pos != 100) send_clean(1);
    gen_word(w);
    put_beat(w, 2'b11, 1'b1, 1'b0, 1'b0);
    send_clean(300);
    check_eq("frame_err_once", 32'(last_cnt), 32'd1);

    // Invalid vldb, relock, clear coincident with a last error
    gen_word(w);
    put_beat(w, 2'b01, 1'b0, 1'b0, 1'b0);
    check_eq("vldb_cnt", 32'(vldb_cnt), 32'd1);
    send_clean(1);
    check_eq("vldb_unlock", 32'(lock), 32'd0);
    send_clean(20);
    while (tb_pos != 50) send_clean(1);
    gen_word(w);
    put_beat(w, 2'b11, 1'b1, 1'b1, 1'b0);
    send_clean(3);
    check_eq("clear_bit_cnt", bit_cnt, 32'd0);
    check_eq("clear_last_cnt", 32'(last_cnt), 32'd0);
    check_eq("clear_vldb_cnt", 32'(vldb_cnt), 32'd0);

`ifdef PRBS_CHK_ERR_INJECT_EN
    gen_word(w);
    put_beat(w, 2'b11, 1'b0, 1'b0, 1'b1);
    send_clean(3);
    check_eq("inject_bits", bit_cnt, 32'd3);
`endif

    // Reset with an errored beat in flight
    gen_word(w);
    w[9] = ~w[9];
    put_beat(w, 2'b11, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Last error counter saturation
    for (int k = 0; k < 66000; k++) begin
      gen_word(w);
      put_beat(w, 2'b11, 1'b1, 1'b0, 1'b0);
    end
    check_eq("last_cnt_sat", 32'(last_cnt), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
